qsys_10g_button_poller: RTL and testbench
=========================================

# qsys_10g_button_poller

Avalon-MM master that periodically reads the button PIO data register over the 10G subsystem fabric, debounces each bit, and presents stable levels, one-cycle press/release pulses and sticky edge-capture bits to local logic. It sits beside the button PIO slave on the 156.25 MHz clock domain and replaces software polling of the buttons.

## Interface
- WIDTH, 4: number of button bits, taken from readdata[WIDTH-1:0]
- POLL_CYCLES, 156250: clk cycles between read issues (1 ms at 156.25 MHz); minimum 2
- READ_LATENCY, 1: fixed slave read latency in cycles after acceptance; minimum 1
- DEBOUNCE_SAMPLES, 4: consecutive differing samples required to change a stable bit; minimum 1
- PIO_ADDR, 0: 2-bit word address driven on avm_address
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- avm_address  out  2  constant PIO_ADDR
- avm_read  out  1  read request
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall; tie 0 for the PIO
- buttons  out  WIDTH  debounced stable level
- press  out  WIDTH  one-cycle pulse, stable bit 0->1
- release  out  WIDTH  one-cycle pulse, stable bit 1->0
- edge_capture  out  WIDTH  sticky OR of press
- edge_clear  in  WIDTH  write-1-to-clear for edge_capture
- sample_valid  out  1  one-cycle pulse per completed read

## Operation
- FSM states: IDLE, READ, WAIT.
- IDLE: poll timer counts down; at 0 -> READ, timer reloads POLL_CYCLES-1.
- READ: avm_read=1; held while avm_waitrequest=1; accepted when waitrequest=0 -> WAIT with latency counter = READ_LATENCY-1.
- WAIT: counter decrements; at 0, avm_readdata[WIDTH-1:0] is sampled on this edge -> IDLE.
- Timer runs in all states; if it reaches 0 before the FSM returns to IDLE, it holds at 0 and the next read issues on the first IDLE cycle (no reads dropped, no back-to-back overlap).
- Debounce per bit: sample==stable -> count<=0; sample!=stable -> count++; when count reaches DEBOUNCE_SAMPLES-1 and the sample still differs, stable<=sample and count<=0.
- press/release: derived from the stable-bit transition, asserted on the same cycle buttons changes.
- edge_capture: bit set by press, cleared by edge_clear; press and clear on the same cycle -> set wins.
- Bits 31:WIDTH of readdata ignored.

## Timing
- Reset values: avm_read 0, buttons 0, press 0, release 0, edge_capture 0, sample_valid 0, debounce counts 0, FSM IDLE, timer POLL_CYCLES-1.
- First read issues POLL_CYCLES cycles after reset deassertion.
- Read accepted in cycle T -> readdata sampled at end of cycle T+READ_LATENCY -> sample_valid, buttons, press, release valid in cycle T+READ_LATENCY+1.
- edge_capture updates the cycle after press; edge_clear takes effect the next cycle.
- Reset mid-transaction: FSM aborts to IDLE, all state returns to reset values; a late readdata is ignored.

## Configuration
- BUTTON_POLLER_DEBOUNCE_EN defined: debounce counters as above.
- Undefined: counters removed; stable<=sample on every sample_valid (DEBOUNCE_SAMPLES ignored), so a change appears after one read.

## Structure
- Shared package qsys_10g_pkg: FSM state enum (IDLE/READ/WAIT), PIO_DATA_ADDR constant (0), default poll period constant.
- One sub-module: qsys_10g_debounce_bit (per-bit counter plus stable register), instantiated WIDTH times by generate; press/release/edge logic stays in the top.

## Test plan
POLL_CYCLES=8, READ_LATENCY=1, DEBOUNCE_SAMPLES=3, WIDTH=4 unless noted.
- Reset release, readdata=0 -> avm_read first high cycle 8, then every 8 cycles; buttons=0, no pulses.
- readdata held 4'b0101 -> buttons=0101 after 3rd read; press=0101 for exactly one cycle; edge_capture=0101 next cycle.
- readdata toggles 0001/0000 each read -> buttons never changes, no press/release.
- avm_waitrequest high 12 cycles during READ -> avm_read held 12+1 cycles; next read issued immediately on return to IDLE.
- edge_capture=0001, edge_clear=0001 on the same cycle as new press on bit0 -> edge_capture stays 0001; clear alone -> 0000.
- reset_n low during WAIT -> all outputs 0 next cycle; with macro undefined, 0010 reflected in buttons after one read.

Source files
------------

// File: rtl/qsys_10g_pkg.sv
// Shared definitions for the 10G subsystem control blocks: poller FSM states,
// PIO register map and default poll period.
package qsys_10g_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } poll_state_e;

    localparam logic [1:0] PIO_DATA_ADDR       = 2'd0;
    localparam int         DEFAULT_POLL_CYCLES = 156250;

endpackage

// File: rtl/qsys_10g_debounce_bit.sv
// One button bit: stable-level register plus, with BUTTON_POLLER_DEBOUNCE_EN,
// a counter of consecutive samples that disagree with the stable level.
module qsys_10g_debounce_bit #(
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en,
    input  logic sample,
    output logic stable,
    output logic stable_nxt
);

    logic stable_q, stable_d;

`ifdef BUTTON_POLLER_DEBOUNCE_EN
    localparam int            CW   = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SAMPLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        stable_d = stable_q;
        count_d  = count_q;
        if (sample_en) begin
            if (sample == stable_q) begin
                count_d = '0;
            end else if (count_q == LAST) begin
                stable_d = sample;
                count_d  = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end
`else
    localparam int unused_samples = DEBOUNCE_SAMPLES;

    always_comb begin
        stable_d = stable_q;
        if (sample_en) stable_d = sample;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_q <= 1'b0;
        else          stable_q <= stable_d;
    end

    assign stable     = stable_q;
    assign stable_nxt = stable_d;

endmodule

// File: rtl/qsys_10g_button_poller.sv
// Avalon-MM master polling the button PIO, debouncing each bit and producing
// levels, press/release pulses and sticky edge bits. Debounce: BUTTON_POLLER_DEBOUNCE_EN.
module qsys_10g_button_poller
    import qsys_10g_pkg::*;
#(
    parameter int         WIDTH            = 4,
    parameter int         POLL_CYCLES      = DEFAULT_POLL_CYCLES,
    parameter int         READ_LATENCY     = 1,
    parameter int         DEBOUNCE_SAMPLES = 4,
    parameter logic [1:0] PIO_ADDR         = PIO_DATA_ADDR
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    output logic [WIDTH-1:0] buttons,
    output logic [WIDTH-1:0] press,
    // release is a reserved word, hence the suffix
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] edge_capture,
    input  logic [WIDTH-1:0] edge_clear,
    output logic             sample_valid
);

    localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    poll_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic             wait_done;
    logic [WIDTH-1:0] stable, stable_nxt;
    logic [WIDTH-1:0] press_q, press_d, release_q, release_d, edge_q, edge_d;
    logic             sample_valid_q;
    logic             unused_rd;

    assign unused_rd = &{1'b0, avm_readdata};

    // Timer free-runs in every state and parks at 0, so a poll that comes due
    // mid-transaction issues on the first IDLE cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q == '0) ? '0 : timer_q - 1'b1;
        lat_d     = lat_q;
        avm_read  = 1'b0;
        wait_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (timer_q == '0) begin
                    state_d = READ;
                    timer_d = TW'(POLL_CYCLES - 1);
                end
            end
            READ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    state_d = WAIT;
                    lat_d   = LW'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    wait_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= TW'(POLL_CYCLES - 1);
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lat_q   <= lat_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        qsys_10g_debounce_bit #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_db (
            .clk        (clk),
            .reset_n    (reset_n),
            .sample_en  (wait_done),
            .sample     (avm_readdata[i]),
            .stable     (stable[i]),
            .stable_nxt (stable_nxt[i])
        );
    end

    // Pulses come from the stable bits' next value so they line up with buttons.
    always_comb begin
        press_d   = stable_nxt & ~stable;
        release_d = ~stable_nxt & stable;
        edge_d    = (edge_q & ~edge_clear) | press_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q        <= '0;
            release_q      <= '0;
            edge_q         <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            press_q        <= press_d;
            release_q      <= release_d;
            edge_q         <= edge_d;
            sample_valid_q <= wait_done;
        end
    end

    assign avm_address   = PIO_ADDR;
    assign buttons       = stable;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign edge_capture  = edge_q;
    assign sample_valid  = sample_valid_q;

endmodule

// File: tb/tb_qsys_10g_button_poller.sv
// Directed bench for qsys_10g_button_poller: poll timing, debounce table,
// waitrequest stall, edge capture set/clear priority and mid-read reset.
module tb_qsys_10g_button_poller;

    localparam int W = 4;
`ifdef BUTTON_POLLER_DEBOUNCE_EN
    localparam int NR = 3;
`else
    localparam int NR = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata = '0;
    logic          avm_waitrequest = 1'b0;
    logic [W-1:0]  buttons, press, release_pulse, edge_capture;
    logic [W-1:0]  edge_clear = '0;
    logic          sample_valid;

    int n_cmp = 0;
    int n_err = 0;

    qsys_10g_button_poller #(
        .WIDTH(W), .POLL_CYCLES(8), .READ_LATENCY(1), .DEBOUNCE_SAMPLES(3), .PIO_ADDR(2'd0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest), .buttons(buttons),
        .press(press), .release_pulse(release_pulse), .edge_capture(edge_capture),
        .edge_clear(edge_clear), .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rd;
        logic [W-1:0] btn;
        logic [W-1:0] prs;
        logic [W-1:0] rls;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive readdata, then return at the negedge of the cycle where sample_valid pulses.
    task automatic do_read(input logic [W-1:0] rd);
        bit seen = 0;
        avm_readdata = {28'h0, rd};
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (sample_valid) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL read_timeout: got no sample_valid expected pulse at %0t", $time);
        end
    endtask

    task automatic wait_read();
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (avm_read) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL read_issue_timeout: got avm_read=0 expected 1 at %0t", $time);
        end
    endtask

    task automatic pulse_clear(input logic [W-1:0] c);
        edge_clear = c;
        @(posedge clk);
        #1 edge_clear = '0;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] ec_exp;

`ifdef BUTTON_POLLER_DEBOUNCE_EN
        tbl[0] = '{4'h5, 4'h0, 4'h0, 4'h0};
        tbl[1] = '{4'h5, 4'h0, 4'h0, 4'h0};
        tbl[2] = '{4'h5, 4'h5, 4'h5, 4'h0};
        tbl[3] = '{4'h1, 4'h5, 4'h0, 4'h0};
        tbl[4] = '{4'h0, 4'h5, 4'h0, 4'h0};
        tbl[5] = '{4'h1, 4'h1, 4'h0, 4'h4};
        tbl[6] = '{4'h0, 4'h1, 4'h0, 4'h0};
        tbl[7] = '{4'h1, 4'h1, 4'h0, 4'h0};
        tbl[8] = '{4'h0, 4'h1, 4'h0, 4'h0};
        tbl[9] = '{4'h1, 4'h1, 4'h0, 4'h0};
`else
        tbl[0] = '{4'h5, 4'h5, 4'h5, 4'h0};
        tbl[1] = '{4'h5, 4'h5, 4'h0, 4'h0};
        tbl[2] = '{4'h5, 4'h5, 4'h0, 4'h0};
        tbl[3] = '{4'h1, 4'h1, 4'h0, 4'h4};
        tbl[4] = '{4'h0, 4'h0, 4'h0, 4'h1};
        tbl[5] = '{4'h1, 4'h1, 4'h1, 4'h0};
        tbl[6] = '{4'h0, 4'h0, 4'h0, 4'h1};
        tbl[7] = '{4'h1, 4'h1, 4'h1, 4'h0};
        tbl[8] = '{4'h0, 4'h0, 4'h0, 4'h1};
        tbl[9] = '{4'h1, 4'h1, 4'h1, 4'h0};
`endif

        // Reset state and poll cadence: reads at cycles 8 and 16, sample at 10.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_address", 32'(avm_address), 32'h0);
        chk("rst_edge", 32'(edge_capture), 32'h0);
        chk("rst_release", 32'(release_pulse), 32'h0);
        for (int n = 0; n <= 16; n++) begin
            if (n > 0) @(negedge clk);
            chk($sformatf("cad_read_c%0d", n), 32'(avm_read), 32'(n == 8 || n == 16));
            chk($sformatf("cad_valid_c%0d", n), 32'(sample_valid), 32'(n == 10));
            chk($sformatf("cad_btn_c%0d", n), 32'(buttons), 32'h0);
            chk($sformatf("cad_press_c%0d", n), 32'(press), 32'h0);
        end

        // Table: debounce behaviour, one-cycle pulses, sticky edge capture.
        ec_exp = '0;
        for (int i = 0; i < 10; i++) begin
            do_read(tbl[i].rd);
            chk($sformatf("tbl%0d_btn", i), 32'(buttons), 32'(tbl[i].btn));
            chk($sformatf("tbl%0d_press", i), 32'(press), 32'(tbl[i].prs));
            chk($sformatf("tbl%0d_release", i), 32'(release_pulse), 32'(tbl[i].rls));
            ec_exp = ec_exp | tbl[i].prs;
            @(negedge clk);
            chk($sformatf("tbl%0d_press_off", i), 32'(press), 32'h0);
            chk($sformatf("tbl%0d_release_off", i), 32'(release_pulse), 32'h0);
            chk($sformatf("tbl%0d_edge", i), 32'(edge_capture), 32'(ec_exp));
        end

        // Waitrequest stall: 12 stalled READ cycles, then accept on the 13th.
        avm_waitrequest = 1'b1;
        wait_read();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("stall_read_%0d", k), 32'(avm_read), 32'h1);
        end
        @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("stall_accept_read", 32'(avm_read), 32'h1);
        @(negedge clk);
        chk("stall_wait_read", 32'(avm_read), 32'h0);
        @(negedge clk);
        chk("stall_valid", 32'(sample_valid), 32'h1);
        chk("stall_idle_read", 32'(avm_read), 32'h0);
        @(negedge clk);
        chk("stall_reissue", 32'(avm_read), 32'h1);

        // Edge capture: clear alone, then press colliding with clear.
        pulse_clear(4'hf);
        chk("clr_all", 32'(edge_capture), 32'h0);
        for (int k = 0; k < NR; k++) do_read(4'h0);
        chk("edge_rel_btn", 32'(buttons), 32'h0);
        for (int k = 0; k < NR; k++) do_read(4'h1);
        chk("edge_prs1", 32'(press), 32'h1);
        @(negedge clk);
        chk("edge_set1", 32'(edge_capture), 32'h1);
        for (int k = 0; k < NR; k++) do_read(4'h0);
        for (int k = 0; k < NR; k++) do_read(4'h1);
        chk("edge_prs2", 32'(press), 32'h1);
        pulse_clear(4'h1);
        chk("edge_set_wins", 32'(edge_capture), 32'h1);
        pulse_clear(4'h1);
        chk("edge_clear_alone", 32'(edge_capture), 32'h0);

        // Reset during WAIT, then a fresh value comes through.
        avm_readdata = 32'h2;
        wait_read();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_read", 32'(avm_read), 32'h0);
        chk("mrst_btn", 32'(buttons), 32'h0);
        chk("mrst_press", 32'(press), 32'h0);
        chk("mrst_release", 32'(release_pulse), 32'h0);
        chk("mrst_edge", 32'(edge_capture), 32'h0);
        chk("mrst_valid", 32'(sample_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < NR; k++) do_read(4'h2);
        chk("mrst_new_btn", 32'(buttons), 32'h2);
        chk("mrst_new_press", 32'(press), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
